// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first eligible request after last_owner, wrapping, with
// last_owner itself examined last.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx
);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W:0]     sum;
    logic [IDX_W-1:0]   idx;

    assign eligible = req & ~mask;

    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise an unassigned path infers a latch.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_idx = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_owner} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among
// NUM_REQ producers; the transfer path is combinational, the grant registered.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        reqIn,
    input  logic [NUM_REQ*DATA_W-1:0] dataBus,
    output logic [NUM_REQ-1:0]        grantOut,
    output logic [NUM_REQ-1:0]        ackOut,
    input  logic                      fifoFull,
    output logic                      fifoEnqueue,
    output logic [DATA_W-1:0]         fifoDataIn,
    output logic                      busy
);

    localparam int IDX_W  = clog2(NUM_REQ);
    localparam int BEAT_W = clog2(MAX_BURST + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]  RST_LAST_OWNR = IDX_W'(NUM_REQ - 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   last_owner;
    logic [BEAT_W-1:0]  beat_cnt;

    logic               owner_req;
    logic               xfer;
    logic               release_grant;
    logic               pick_found;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;

    // The grant is one-hot, so a reduction over grant & req is the owner's request.
    assign owner_req     = |(grantOut & reqIn);
    assign xfer          = owner_req & ~fifoFull;
    assign release_grant = ~owner_req | (xfer & (beat_cnt == LAST_BEAT));

    assign fifoEnqueue = xfer;
    assign ackOut      = grantOut & {NUM_REQ{xfer}};
    assign busy        = (state == HOLD);

    always_comb begin
        fifoDataIn = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantOut[i]) begin
                fifoDataIn = dataBus[i*DATA_W +: DATA_W];
            end
        end
    end

    // Masking with the current grant excludes the owner on release; in IDLE
    // the grant is zero so every requester is eligible.
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (reqIn),
        .last_owner (last_owner),
        .mask       (grantOut),
        .found      (pick_found),
        .pick       (pick_onehot),
        .pick_idx   (pick_idx)
    );

    // The owner is always the latest pick, so last_owner doubles as the owner
    // index and the rr search naturally starts just past the owner.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grantOut   <= '0;
            beat_cnt   <= '0;
            last_owner <= RST_LAST_OWNR;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state      <= HOLD;
                        grantOut   <= pick_onehot;
                        last_owner <= pick_idx;
                        beat_cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (release_grant) begin
                        beat_cnt <= '0;
                        if (pick_found) begin
                            grantOut   <= pick_onehot;
                            last_owner <= pick_idx;
                        end else if (!owner_req) begin
                            grantOut <= '0;
                            state    <= IDLE;
                        end
                        // Otherwise the owner alone still requests: re-grant it.
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    grantOut <= '0;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a session-level reference model
// predicts each accepted word; a negedge monitor compares against the DUT.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   reqIn;
    logic [N*W-1:0] dataBus;
    logic [N-1:0]   grantOut;
    logic [N-1:0]   ackOut;
    logic           fifoFull;
    logic           fifoEnqueue;
    logic [W-1:0]   fifoDataIn;
    logic           busy;

    fifo_write_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (W),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqIn       (reqIn),
        .dataBus     (dataBus),
        .grantOut    (grantOut),
        .ackOut      (ackOut),
        .fifoFull    (fifoFull),
        .fifoEnqueue (fifoEnqueue),
        .fifoDataIn  (fifoDataIn),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] log_q[$];
    int           checks    = 0;
    int           errors    = 0;
    int           enq_count = 0;

    // Producer word stores (circular) and reference-model state.
    logic [W-1:0] pmem [N][64];
    int           phead  [N];
    int           pcount [N];
    int           m_owner  = -1;
    int           m_last   = N - 1;
    int           m_beats  = 0;
    bit           exp_xfer = 1'b0;
    int           arrive_pct = 0;
    int           full_pct   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input int i, input logic [W-1:0] d);
        pmem[i][(phead[i] + pcount[i]) % 64] = d;
        pcount[i]++;
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] req, input int excl);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (j != excl && req[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (pcount[i] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_last   = N - 1;
        m_beats  = 0;
        exp_xfer = 1'b0;
        exp_q.delete();
    endtask

    // Applies the arbitration rules to the inputs that were stable before this edge.
    task automatic model_edge();
        bit xfer;
        int nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        xfer = (m_owner >= 0) && reqIn[m_owner] && !fifoFull;
        if (xfer) begin
            phead[m_owner]  = (phead[m_owner] + 1) % 64;
            pcount[m_owner] = pcount[m_owner] - 1;
            m_beats++;
        end
        if (m_owner < 0) begin
            if (reqIn != '0) begin
                m_owner = rr_next(m_last, reqIn, -1);
                m_last  = m_owner;
                m_beats = 0;
            end
        end else if (!reqIn[m_owner] || (xfer && m_beats == MB)) begin
            nxt = rr_next(m_last, reqIn, m_owner);
            if (nxt >= 0) begin
                m_owner = nxt;
                m_last  = nxt;
                m_beats = 0;
            end else if (reqIn[m_owner]) begin
                m_beats = 0;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic arrivals();
        if (arrive_pct > 0) begin
            for (int i = 0; i < N; i++) begin
                if (pcount[i] < 40 && $urandom_range(99) < arrive_pct) begin
                    repeat ($urandom_range(1, 5)) push_word(i, W'($urandom));
                end
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            reqIn[i] = (pcount[i] != 0);
            dataBus[i*W +: W] = (pcount[i] != 0) ? pmem[i][phead[i]] : W'($urandom);
        end
        fifoFull = ($urandom_range(99) < full_pct);
        exp_xfer = rst_n && (m_owner >= 0) && reqIn[m_owner] && !fifoFull;
        if (exp_xfer) begin
            exp_q.push_back('{id: m_owner, data: pmem[m_owner][phead[m_owner]]});
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            arrivals();
            drive_inputs();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (all_empty() && m_owner < 0) begin
                done = 1'b1;
                break;
            end
            run_cycles(1);
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin : monitor
        logic [N-1:0] exp_grant;
        exp_t         e;
        exp_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
        check("grant", 32'(grantOut), 32'(exp_grant));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("enqueue", 32'(fifoEnqueue), 32'(exp_xfer));
        if (grantOut == '0) check("data_idle", 32'(fifoDataIn), 32'd0);
        if (fifoEnqueue) begin
            enq_count++;
            log_q.push_back(fifoDataIn);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_enqueue: got enqueue of 0x%0h, expected none", fifoDataIn);
            end else begin
                e = exp_q.pop_front();
                check("ack", 32'(ackOut), 32'(N'(1) << e.id));
                check("data", 32'(fifoDataIn), 32'(e.data));
            end
        end else begin
            check("ack_idle", 32'(ackOut), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            phead[i]  = 0;
            pcount[i] = 0;
        end
        model_reset();

        // Reset with every producer requesting.
        for (int i = 0; i < N; i++) repeat (3) push_word(i, W'($urandom));
        drive_inputs();
        run_cycles(2);
        check("reset_grant", 32'(grantOut), 32'd0);
        check("reset_enqueue", 32'(fifoEnqueue), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        run_cycles(1);
        check("first_grant", 32'(grantOut), 32'b0001);
        drain();

        // Single producer, three words, then release to IDLE.
        log_q.delete();
        e0 = enq_count;
        push_word(0, 8'hF0);
        push_word(0, 8'h0F);
        push_word(0, 8'h01);
        drive_inputs();
        run_cycles(5);
        check("single_count", 32'(enq_count - e0), 32'd3);
        check("single_log_size", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            check("single_w0", 32'(log_q[0]), 32'hF0);
            check("single_w1", 32'(log_q[1]), 32'h0F);
            check("single_w2", 32'(log_q[2]), 32'h01);
        end
        check("single_idle", 32'(busy), 32'd0);

        // Burst limit between producers 0 and 2 (last owner is 0 here).
        e0 = enq_count;
        repeat (8) push_word(0, W'($urandom));
        repeat (8) push_word(2, W'($urandom));
        drive_inputs();
        run_cycles(1);
        check("burst_first", 32'(grantOut), 32'b0100);
        run_cycles(4);
        check("burst_rot1", 32'(grantOut), 32'b0001);
        run_cycles(4);
        check("burst_rot2", 32'(grantOut), 32'b0100);
        check("burst_nogap", 32'(enq_count - e0), 32'd9);
        drain();

        // Full stall mid-burst: owner 1 at beat 2, five full cycles.
        repeat (8) push_word(1, W'($urandom));
        repeat (4) push_word(3, W'($urandom));
        drive_inputs();
        run_cycles(2);
        full_pct = 100;
        e0 = enq_count;
        run_cycles(5);
        check("stall_no_enqueue", 32'(enq_count - e0), 32'd0);
        check("stall_grant_kept", 32'(grantOut), 32'b0010);
        full_pct = 0;
        e0 = enq_count;
        run_cycles(2);
        check("stall_resume_words", 32'(enq_count - e0), 32'd2);
        run_cycles(1);
        check("stall_rotate", 32'(grantOut), 32'b1000);
        drain();

        // Fairness from a fresh reset: 0,1,2,3,0,1,2,3 with four words each.
        rst_n = 1'b0;
        model_reset();
        run_cycles(1);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) repeat (8) push_word(i, W'($urandom));
        drive_inputs();
        e0 = enq_count;
        for (int k = 0; k < 8; k++) begin
            run_cycles(k == 0 ? 1 : 4);
            check("fair_grant", 32'(grantOut), 32'(N'(1) << (k % N)));
        end
        run_cycles(3);
        check("fair_total", 32'(enq_count - e0), 32'd32);
        drain();
        check("fair_no_extra", 32'(enq_count - e0), 32'd32);

        // Randomized traffic with random FIFO back-pressure.
        arrive_pct = 20;
        full_pct   = 25;
        run_cycles(1500);
        arrive_pct = 0;
        full_pct   = 0;
        drain();

        // Asynchronous reset between edges while a word is in flight.
        repeat (6) push_word(2, W'($urandom));
        drive_inputs();
        run_cycles(2);
        check("pre_reset_enqueue", 32'(fifoEnqueue), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_grant", 32'(grantOut), 32'd0);
        check("async_enqueue", 32'(fifoEnqueue), 32'd0);
        check("async_ack", 32'(ackOut), 32'd0);
        for (int i = 0; i < N; i++) pcount[i] = 0;
        drive_inputs();
        run_cycles(2);
        rst_n = 1'b1;
        #1;
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_grant", 32'(grantOut), 32'd0);
        run_cycles(3);
        check("post_reset_idle", 32'(busy), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the 8-bit FIFO (dataIn/enqueue/full) between NUM_REQ producers.
- Round-robin grant with a bounded burst per grant; stalls on FIFO full.
- The consumer side of the FIFO (dequeue/dataOut/empty) does not pass through this block.
- Sits directly in front of the FIFO.

Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 8, word width; matches the FIFO dataIn width
- MAX_BURST, 4, maximum transferred words per grant (1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- reqIn  input  NUM_REQ  per-producer request; held high while the producer has data
- dataBus  input  NUM_REQ*DATA_W  producer words; slice i = bits [i*DATA_W +: DATA_W]
- grantOut  output  NUM_REQ  one-hot registered grant, or all zero
- ackOut  output  NUM_REQ  word from producer i accepted this cycle (combinational)
- fifoFull  input  1  FIFO full flag
- fifoEnqueue  output  1  FIFO enqueue strobe (combinational)
- fifoDataIn  output  DATA_W  FIFO write data (combinational mux)
- busy  output  1  high when state is HOLD

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - state=IDLE, grantOut=0, beatCnt=0, lastOwner=NUM_REQ-1.
  - Combinational outputs therefore 0.
- Transfer condition: xfer = grantOut[i] & reqIn[i] & ~fifoFull for owner i.
  - fifoEnqueue = xfer.
  - ackOut = grantOut & {NUM_REQ{xfer}}.
  - fifoDataIn = dataBus slice of owner. Drive 0 when grantOut==0.
- Round-robin pick: the first set reqIn bit searching lastOwner+1 upward, wrapping. lastOwner is checked last.
- States:
  - IDLE:
    - If reqIn!=0, at the edge: grant the rr pick, owner=pick, lastOwner=pick, beatCnt=0, go to HOLD.
    - The first transfer can occur the cycle after reqIn rises (1-cycle grant latency).
  - HOLD, evaluated each edge in priority order:
    - (a) If reqIn[owner]==0, release.
    - (b) Else if xfer and beatCnt==MAX_BURST-1, release.
    - (c) Else if xfer, beatCnt+1.
    - (d) Else hold. Stall on fifoFull: no count, grant kept indefinitely.
  - Release:
    - Compute the rr pick over the current reqIn with owner masked out.
    - If a pick exists, grant it directly (HOLD, beatCnt=0, lastOwner=pick), with no idle cycle.
    - If no other requester but the owner still requests (burst-limit case), re-grant the owner with beatCnt=0.
    - Otherwise, grantOut=0 and go to IDLE.
- Boundaries:
  - MAX_BURST=1 rotates after every word.
  - beatCnt width = clog2(MAX_BURST+1).
  - Requesters that are not the owner never get ackOut.
  - Producer data must be held until ackOut.
  - reqIn changes by non-owners never disturb the current grant.
  - rst_n low mid-burst clears the grant immediately (asynchronously). The in-flight cycle's enqueue drops at once.

Decomposition:
- Package fifo_arb_pkg: state enum {IDLE, HOLD}; localparams for default NUM_REQ/DATA_W/MAX_BURST; function clog2.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: req vector, lastOwner, mask.
  - Outputs: found, one-hot pick, pick index.

Test Plan (NUM_REQ=4, DATA_W=8, MAX_BURST=4):
- Reset: rst_n=0 with reqIn=4'b1111 -> grantOut=0, fifoEnqueue=0, busy=0. Release reset -> grantOut=4'b0001 one cycle later (lastOwner reset =3).
- Single producer: req0 high, data 8'hF0,8'h0F,8'h01 presented on ack -> fifoEnqueue high 3 cycles, fifoDataIn F0,0F,01. Drop req0 -> IDLE next edge.
- Burst limit: req0 and req2 held high -> producer 0 gets 4 words, then grantOut=4'b0100 on the next edge with no gap; 4 words later back to 4'b0001.
- Full stall: owner 1 mid-burst (beatCnt=2), fifoFull=1 for 5 cycles -> fifoEnqueue=0, ackOut=0, grant kept. Full drops -> exactly 2 more words, then rotate.
- Fairness: all four requesting continuously for 32 cycles -> grant order 0,1,2,3,0,... with 4 words each; 32 enqueues total.
- Async reset mid-burst: assert rst_n between clock edges while transferring -> grantOut and fifoEnqueue drop immediately without a clock; state is IDLE after release.
